// File: rtl/fifo_preempt_arbiter.sv
// rtl/fifo_preempt_arbiter.sv - round-robin arbiter sharing one FWFT readout port between N sources
// Burst-limited round robin; a preempting source jumps the queue and holds the grant until it drains or drops the request.
module fifo_preempt_arbiter #(
  parameter int N_SOURCES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                            BUS_CLK,
  input  logic                            BUS_RST,
  input  logic [N_SOURCES-1:0]            SRC_EMPTY,
  input  logic [N_SOURCES*DATA_WIDTH-1:0] SRC_DATA,
  input  logic [N_SOURCES-1:0]            SRC_PREEMPT_REQ,
  output logic [N_SOURCES-1:0]            SRC_READ,
  input  logic                            OUT_READ,
  output logic                            OUT_EMPTY,
  output logic [DATA_WIDTH-1:0]           OUT_DATA,
  output logic [N_SOURCES-1:0]            GRANT,
  output logic                            GRANT_VALID
);

  localparam int IW = $clog2(N_SOURCES);
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [CW-1:0]        BURST_MAX = CW'(MAX_BURST);
  localparam logic [IW-1:0]        LAST_RST  = IW'(N_SOURCES - 1);
  localparam logic [N_SOURCES-1:0] ONE_HOT0  = N_SOURCES'(1);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_GRANTED = 1'b1;

  logic [0:0]           state;
  logic [IW-1:0]        gidx;
  logic [IW-1:0]        last_idx;
  logic [CW-1:0]        bcnt;

  logic [DATA_WIDTH-1:0] src_word [N_SOURCES];
  logic [N_SOURCES-1:0]  pre_cand;
  logic [N_SOURCES-1:0]  search_mask;
  logic [N_SOURCES-1:0]  pick_mask;
  logic [IW-1:0]         pick;
  logic                  found;
  logic                  cur_empty;
  logic                  cur_pre;
  logic                  rd_fire;
  logic                  others_pre;
  logic                  release_now;
  logic [CW-1:0]         bcnt_inc;

  // Index arithmetic for the wrap-around search; N_SOURCES need not be a power of two.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_SOURCES) s = s - N_SOURCES;
    return IW'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < N_SOURCES; i++) begin
      src_word[i] = SRC_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign GRANT_VALID = (state == ST_GRANTED);
  assign cur_empty   = SRC_EMPTY[gidx];
  assign cur_pre     = SRC_PREEMPT_REQ[gidx];

  // Zero-latency passthrough of the granted source's FWFT head word.
  assign OUT_EMPTY = ~GRANT_VALID | cur_empty;
  assign OUT_DATA  = GRANT_VALID ? src_word[gidx] : '0;
  assign rd_fire   = OUT_READ & GRANT_VALID & ~cur_empty & ~BUS_RST;
  assign SRC_READ  = rd_fire ? GRANT : '0;

  assign pre_cand    = SRC_PREEMPT_REQ & ~SRC_EMPTY;
  assign search_mask = (|pre_cand) ? pre_cand : ~SRC_EMPTY;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int off = 1; off <= N_SOURCES; off++) begin
      if (!found && search_mask[wrap_idx(last_idx, off)]) begin
        found = 1'b1;
        pick  = wrap_idx(last_idx, off);
      end
    end
  end

  assign pick_mask = ONE_HOT0 << pick;

  // Release includes this cycle's read, so the last word of a burst is never split.
  assign bcnt_inc    = (rd_fire && (bcnt != BURST_MAX)) ? bcnt + CW'(1) : bcnt;
  assign others_pre  = |(pre_cand & ~GRANT);
  assign release_now = cur_empty
                     | (~cur_pre & (bcnt_inc == BURST_MAX))
                     | (~cur_pre & others_pre);

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state    <= ST_IDLE;
      GRANT    <= '0;
      gidx     <= '0;
      last_idx <= LAST_RST;
      bcnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state    <= ST_GRANTED;
            GRANT    <= pick_mask;
            gidx     <= pick;
            last_idx <= pick;
            bcnt     <= '0;
          end
        end
        default: begin
          bcnt <= bcnt_inc;
          if (release_now) begin
            state <= ST_IDLE;
            GRANT <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_preempt_arbiter.sv
// tb/tb_fifo_preempt_arbiter.sv - scoreboard bench for fifo_preempt_arbiter
module tb_fifo_preempt_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 16;

  logic            BUS_CLK = 1'b0;
  logic            BUS_RST;
  logic [N-1:0]    SRC_EMPTY;
  logic [N*DW-1:0] SRC_DATA;
  logic [N-1:0]    SRC_PREEMPT_REQ;
  logic [N-1:0]    SRC_READ;
  logic            OUT_READ;
  logic            OUT_EMPTY;
  logic [DW-1:0]   OUT_DATA;
  logic [N-1:0]    GRANT;
  logic            GRANT_VALID;

  fifo_preempt_arbiter #(.N_SOURCES(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .SRC_EMPTY(SRC_EMPTY), .SRC_DATA(SRC_DATA),
    .SRC_PREEMPT_REQ(SRC_PREEMPT_REQ), .SRC_READ(SRC_READ), .OUT_READ(OUT_READ),
    .OUT_EMPTY(OUT_EMPTY), .OUT_DATA(OUT_DATA), .GRANT(GRANT), .GRANT_VALID(GRANT_VALID)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] src_q   [N][$];
  logic [31:0] exp_src [N][$];
  logic [31:0] exp_glob [$];
  int          push_seq [N];
  int          exp_seq  [N];

  bit          glob_mode = 1'b1;
  bit          mon_en    = 1'b0;
  bit          pred_ok   = 1'b0;
  logic [N-1:0] rd_latched = '0;
  logic [N-1:0] m_grant = '0;
  logic [N-1:0] m_nxt;
  int           m_last = N - 1;
  int           m_cnt  = 0;
  int           m_gi;
  int           m_win;
  logic         m_oe, m_xfer, m_rel;
  logic [31:0]  m_dat, m_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int rr_find(input logic [N-1:0] mask, input int last);
    for (int off = 1; off <= N; off++) begin
      if (mask[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      SRC_EMPTY[i] = (src_q[i].size() == 0);
      SRC_DATA[i*DW +: DW] = (src_q[i].size() != 0) ? src_q[i][0] : 32'h0;
    end
  endtask

  task automatic push_word(input int s);
    logic [31:0] w;
    w = {4'(s), 28'(push_seq[s])};
    push_seq[s]++;
    src_q[s].push_back(w);
    exp_src[s].push_back(w);
    refresh();
  endtask

  task automatic expect_run(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      exp_glob.push_back({4'(s), 28'(exp_seq[s])});
      exp_seq[s]++;
    end
  endtask

  // Source FIFOs pop on the read strobe seen before the edge; inputs change 1ns after the edge.
  task automatic tick();
    logic [31:0] d;
    @(posedge BUS_CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rd_latched[i] === 1'b1 && src_q[i].size() > 0) d = src_q[i].pop_front();
    end
    refresh();
  endtask

  task automatic wait_grant(input logic [N-1:0] mask, input string name);
    for (int k = 0; k < 200; k++) begin
      tick();
      if (GRANT == mask) break;
    end
    check(name, GRANT, mask);
  endtask

  function automatic bit busy();
    bit b;
    b = (GRANT != 0) || (exp_glob.size() != 0);
    for (int i = 0; i < N; i++) b = b || (src_q[i].size() != 0) || (exp_src[i].size() != 0);
    return b;
  endfunction

  task automatic drain(input string name, input int limit);
    for (int k = 0; k < limit; k++) begin
      if (!busy()) break;
      tick();
    end
    check(name, busy(), 0);
  endtask

  // Monitor: rule-level model of grant decisions plus per-source and global scoreboards.
  always @(negedge BUS_CLK) begin
    rd_latched = SRC_READ;
    if (mon_en) begin
      m_gi   = oh_idx(m_grant);
      m_oe   = (m_grant == 0) || SRC_EMPTY[m_gi];
      m_xfer = OUT_READ && !m_oe && !BUS_RST;
      if (pred_ok) begin
        check("grant", GRANT, m_grant);
        check("grant_valid", GRANT_VALID, |m_grant);
        check("grant_onehot0", $onehot0(GRANT), 1);
        check("out_empty", OUT_EMPTY, m_oe);
        m_dat = (m_grant == 0) ? 32'h0 : SRC_DATA[m_gi*DW +: DW];
        check("out_data", OUT_DATA, m_dat);
        check("src_read", SRC_READ, m_xfer ? m_grant : '0);
        if (m_xfer) begin
          if (exp_src[m_gi].size() == 0) begin
            checks++; errors++;
            $display("FAIL src_order: src %0d got %0h expected no word", m_gi, OUT_DATA);
          end else begin
            m_word = exp_src[m_gi].pop_front();
            check("src_order", OUT_DATA, m_word);
          end
          if (glob_mode) begin
            if (exp_glob.size() == 0) begin
              checks++; errors++;
              $display("FAIL glob_order: got %0h expected no word", OUT_DATA);
            end else begin
              m_word = exp_glob.pop_front();
              check("glob_order", OUT_DATA, m_word);
            end
          end
        end
      end
      if (BUS_RST) begin
        m_nxt = '0; m_last = N - 1; m_cnt = 0;
      end else if (m_grant == 0) begin
        m_win = rr_find(((SRC_PREEMPT_REQ & ~SRC_EMPTY) != 0) ? (SRC_PREEMPT_REQ & ~SRC_EMPTY) : ~SRC_EMPTY, m_last);
        if (m_win >= 0) begin
          m_nxt = '0; m_nxt[m_win] = 1'b1; m_last = m_win; m_cnt = 0;
        end else begin
          m_nxt = '0;
        end
      end else begin
        if (m_xfer && m_cnt < MB) m_cnt++;
        m_rel = SRC_EMPTY[m_gi] ||
                (!SRC_PREEMPT_REQ[m_gi] && ((m_cnt == MB) || ((SRC_PREEMPT_REQ & ~SRC_EMPTY & ~m_grant) != 0)));
        m_nxt = m_rel ? '0 : m_grant;
      end
      m_grant = m_nxt;
      pred_ok = 1'b1;
    end
  end

  initial begin
    int pushed [N];
    int tot;
    int cyc;
    BUS_RST = 1'b1;
    OUT_READ = 1'b0;
    SRC_PREEMPT_REQ = '0;
    for (int i = 0; i < N; i++) begin push_seq[i] = 0; exp_seq[i] = 0; end
    refresh();
    repeat (3) tick();
    mon_en = 1'b1;
    tick();
    BUS_RST = 1'b0;

    // Reset with every source empty, then a stray OUT_READ pulse.
    check("rst_out_data", OUT_DATA, 0);
    for (int k = 0; k < 10; k++) begin
      check("idle_out_empty", OUT_EMPTY, 1);
      check("idle_grant", GRANT, 0);
      check("idle_src_read", SRC_READ, 0);
      tick();
    end
    OUT_READ = 1'b1;
    #1;
    check("pulse_src_read", SRC_READ, 0);
    tick();
    check("pulse_grant", GRANT, 0);

    // Two 40-word sources alternate in bursts of 16.
    for (int k = 0; k < 40; k++) begin push_word(0); push_word(2); end
    expect_run(0, 16); expect_run(2, 16); expect_run(0, 16);
    expect_run(2, 16); expect_run(0, 8);  expect_run(2, 8);
    drain("burst_drain", 400);

    // Preempt on src3 cuts src1 after its 6th word and then holds past 16 words.
    for (int k = 0; k < 20; k++) push_word(1);
    expect_run(1, 6); expect_run(3, 33); expect_run(1, 14);
    wait_grant(4'b0010, "pre_src1_grant");
    repeat (5) tick();
    for (int k = 0; k < 3; k++) push_word(3);
    SRC_PREEMPT_REQ[3] = 1'b1;
    wait_grant(4'b1000, "pre_src3_grant");
    for (int k = 0; k < 30; k++) push_word(3);
    drain("pre_drain", 400);
    SRC_PREEMPT_REQ = '0;

    // Single word, release on empty, later regrant.
    push_word(0); expect_run(0, 1);
    wait_grant(4'b0001, "single_grant");
    wait_grant(4'b0000, "single_release");
    check("single_out_empty", OUT_EMPTY, 1);
    repeat (3) tick();
    push_word(0); expect_run(0, 1);
    wait_grant(4'b0001, "single_regrant");
    drain("single_drain", 50);

    // Reset mid-burst: no word consumed during reset, src2 resumes at its 8th word.
    for (int k = 0; k < 20; k++) push_word(2);
    expect_run(2, 20);
    wait_grant(4'b0100, "rst_src2_grant");
    repeat (7) tick();
    BUS_RST = 1'b1;
    #1;
    check("rst_src_read", SRC_READ, 0);
    tick();
    check("rst_grant_clear", GRANT, 0);
    check("rst_src_depth", src_q[2].size(), 13);
    BUS_RST = 1'b0;
    drain("rst_drain", 100);

    // Randomised traffic with preempts; per-source ordering scoreboard.
    glob_mode = 1'b0;
    for (int i = 0; i < N; i++) pushed[i] = 0;
    tot = 0;
    cyc = 0;
    while (tot < 4 * 1000 && cyc < 30000) begin
      for (int i = 0; i < N; i++) begin
        if (pushed[i] < 1000 && $urandom_range(0, 99) < 22) begin
          push_word(i); pushed[i]++; tot++;
        end
        if ($urandom_range(0, 59) == 0) SRC_PREEMPT_REQ[i] = ~SRC_PREEMPT_REQ[i];
      end
      OUT_READ = ($urandom_range(0, 99) < 75);
      tick();
      cyc++;
    end
    check("rand_pushed", tot, 4000);
    SRC_PREEMPT_REQ = '0;
    OUT_READ = 1'b1;
    drain("rand_drain", 20000);
    for (int i = 0; i < N; i++) check("rand_left", exp_src[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
